// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: Q1.15 sample format and the default tap count,
// so the input FIFO and the filter agree on sample width and pacing.
package fir_pkg;
   localparam int WIDTH        = 16;
   localparam int Q_INT        = 1;
   localparam int Q_FRAC       = 15;
   localparam int DEFAULT_TAPS = 8;

   typedef logic signed [WIDTH-1:0] sample_t;

   localparam sample_t ZERO_SAMPLE = '0;
endpackage

// File: rtl/fir_sample_ram.sv
// DEPTH x WIDTH simple dual-port sample storage; synchronous write, asynchronous read.
// Read data follows rd_addr combinationally; no backpressure, the parent owns all flow control.
module fir_sample_ram #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_dat
);
   import fir_pkg::*;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/fir_input_sample_fifo.sv
// Paced sample FIFO ahead of the single-MAC FIR: one sample (or a zero stuff) every TAPS cycles.
// Push-to-x_out latency >= 2 cycles; no backpressure, pushes into a full FIFO are dropped and flagged.
module fir_input_sample_fifo #(
   parameter int  WIDTH = fir_pkg::WIDTH,
   parameter int  TAPS  = fir_pkg::DEFAULT_TAPS,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] x_in,
   input  logic             x_in_valid,
   output logic [WIDTH-1:0] x_out,
   output logic             x_out_strobe,
   output logic [AW:0]      fifo_count,
   output logic             overflow_error,
   output logic             underrun
);
   import fir_pkg::*;

   localparam int            CW        = $clog2(TAPS);
   localparam logic [CW-1:0] LAST_SLOT = CW'(TAPS - 1);
   localparam logic [WIDTH-1:0] STUFF  = WIDTH'(ZERO_SAMPLE);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_ptr_nxt;
   logic [AW:0]      rd_ptr_nxt;
   logic [CW-1:0]    pace_cnt;
   logic             pop_slot;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;
   logic [WIDTH-1:0] rd_dat;

   assign pop_slot = (pace_cnt == LAST_SLOT);
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop   = pop_slot && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign do_push  = x_in_valid && (!full || do_pop);

   assign wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
   assign rd_ptr_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;

   fir_sample_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .CLK     (CLK),
      .wr_en   (do_push && RST),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_dat  (x_in),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_dat  (rd_dat)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         pace_cnt       <= '0;
         fifo_count     <= '0;
         x_out          <= STUFF;
         x_out_strobe   <= 1'b0;
         underrun       <= 1'b0;
         overflow_error <= 1'b0;
      end else begin
         pace_cnt     <= pop_slot ? '0 : pace_cnt + 1'b1;
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         fifo_count   <= wr_ptr_nxt - rd_ptr_nxt;
         x_out_strobe <= pop_slot;
         underrun     <= pop_slot && empty;
         // An empty slot still strobes a zero so the filter's sample timing never slips.
         if (pop_slot) begin
            x_out <= do_pop ? rd_dat : STUFF;
         end
         if (x_in_valid && full && !pop_slot) begin
            overflow_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fir_input_sample_fifo.sv
// Directed bench for fir_input_sample_fifo at TAPS=4, DEPTH=8 with hand-computed strobe sequences.
module tb_fir_input_sample_fifo;
   localparam int WIDTH = 16;
   localparam int TAPS  = 4;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] x_in;
   logic             x_in_valid;
   logic [WIDTH-1:0] x_out;
   logic             x_out_strobe;
   logic [AW:0]      fifo_count;
   logic             overflow_error;
   logic             underrun;

   int n_cmp   = 0;
   int n_err   = 0;
   int cyc     = 0;
   int max_cnt = 0;
   int n_extra = 0;

   // bit 16: push valid / expected underrun; bits 15:0: sample
   logic [16:0] push_q[$];
   logic [16:0] exp_q[$];

   always #5 CLK = ~CLK;

   fir_input_sample_fifo #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .DEPTH (DEPTH)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .x_in           (x_in),
      .x_in_valid     (x_in_valid),
      .x_out          (x_out),
      .x_out_strobe   (x_out_strobe),
      .fifo_count     (fifo_count),
      .overflow_error (overflow_error),
      .underrun       (underrun)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int n);
      RST        = 1'b0;
      x_in_valid = 1'b0;
      x_in       = '0;
      repeat (n) @(posedge CLK);
      #1;
      RST     = 1'b1;
      cyc     = 0;
      max_cnt = 0;
      n_extra = 0;
      push_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_x_out"},  32'(x_out), 32'h0);
      chk_eq({tag, "_strobe"}, 32'(x_out_strobe), 32'h0);
      chk_eq({tag, "_count"},  32'(fifo_count), 32'h0);
      chk_eq({tag, "_ovf"},    32'(overflow_error), 32'h0);
      chk_eq({tag, "_unr"},    32'(underrun), 32'h0);
   endtask

   // One clock: drive the next queued push, then check the strobe slot and any strobe payload.
   task automatic step();
      logic [16:0] p;
      logic [16:0] e;
      if (push_q.size() > 0) begin
         p          = push_q.pop_front();
         x_in_valid = p[16];
         x_in       = p[15:0];
      end else begin
         x_in_valid = 1'b0;
         x_in       = '0;
      end
      @(posedge CLK);
      #1;
      cyc++;
      chk_eq("strobe_slot", 32'(x_out_strobe), 32'((cyc % TAPS) == 0));
      if (x_out_strobe) begin
         if (exp_q.size() == 0) begin
            n_extra++;
         end else begin
            e = exp_q.pop_front();
            chk_eq("strobe_dat", 32'(x_out), 32'(e[15:0]));
            chk_eq("strobe_unr", 32'(underrun), 32'(e[16]));
         end
      end else begin
         chk_eq("unr_idle", 32'(underrun), 32'h0);
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
   endtask

   task automatic push(input logic [15:0] v);
      push_q.push_back({1'b1, v});
   endtask

   task automatic idle();
      push_q.push_back({1'b0, 16'h0000});
   endtask

   task automatic expect_s(input logic unr, input logic [15:0] v);
      exp_q.push_back({unr, v});
   endtask

   task automatic end_of_test(input string tag);
      chk_eq({tag, "_exp_left"}, 32'(exp_q.size()), 32'h0);
      chk_eq({tag, "_extra"},    32'(n_extra), 32'h0);
   endtask

   initial begin
      RST        = 1'b0;
      x_in       = '0;
      x_in_valid = 1'b0;

      // Idle pacing: zero-stuffed strobes with underrun at ticks 4, 8, 12
      do_reset(2);
      chk_reset_state("rst0");
      for (int i = 0; i < 3; i++) expect_s(1'b1, 16'h0000);
      repeat (12) step();
      chk_eq("pace_max_cnt", 32'(max_cnt), 32'h0);
      end_of_test("pace");

      // Ordered pass-through, bit-exact
      do_reset(1);
      push(16'h4000); push(16'h2AAA); push(16'h8000); push(16'h7FFF);
      expect_s(1'b0, 16'h4000); expect_s(1'b0, 16'h2AAA);
      expect_s(1'b0, 16'h8000); expect_s(1'b0, 16'h7FFF);
      expect_s(1'b1, 16'h0000);
      repeat (20) step();
      chk_eq("pass_max_cnt", 32'(max_cnt), 32'h3);
      chk_eq("pass_end_cnt", 32'(fifo_count), 32'h0);
      end_of_test("pass");

      // Overflow: push 11 is dropped (full, no pop), push 12 lands in a pop slot
      do_reset(1);
      for (int k = 1; k <= 12; k++) push(16'(k));
      for (int k = 1; k <= 10; k++) expect_s(1'b0, 16'(k));
      expect_s(1'b0, 16'h000C);
      expect_s(1'b1, 16'h0000);
      for (int i = 1; i <= 48; i++) begin
         step();
         if (i == 10) chk_eq("ovf_before_drop", 32'(overflow_error), 32'h0);
         if (i == 11) chk_eq("ovf_at_drop", 32'(overflow_error), 32'h1);
      end
      chk_eq("ovf_sticky", 32'(overflow_error), 32'h1);
      chk_eq("ovf_max_cnt", 32'(max_cnt), 32'h8);
      end_of_test("ovf");

      // Reset clears the sticky overflow flag
      do_reset(1);
      chk_reset_state("rst1");

      // Full FIFO with push exactly in a pop slot
      for (int k = 1; k <= 10; k++) push(16'h0010 + 16'(k));
      idle();
      push(16'h1234);
      for (int k = 1; k <= 10; k++) expect_s(1'b0, 16'h0010 + 16'(k));
      expect_s(1'b0, 16'h1234);
      expect_s(1'b1, 16'h0000);
      for (int i = 1; i <= 48; i++) begin
         step();
         if (i == 11) chk_eq("full_cnt_pre", 32'(fifo_count), 32'h8);
         if (i == 12) chk_eq("full_cnt_pp", 32'(fifo_count), 32'h8);
      end
      chk_eq("full_ovf", 32'(overflow_error), 32'h0);
      end_of_test("full");

      // Empty FIFO with push exactly in a pop slot
      do_reset(1);
      idle(); idle(); idle();
      push(16'h5555);
      expect_s(1'b1, 16'h0000);
      expect_s(1'b0, 16'h5555);
      expect_s(1'b1, 16'h0000);
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i == 4) chk_eq("empty_pp_cnt", 32'(fifo_count), 32'h1);
      end
      end_of_test("empty");

      // Mid-operation reset with five samples buffered
      do_reset(1);
      for (int k = 1; k <= 6; k++) push(16'h0A00 + 16'(k));
      expect_s(1'b0, 16'h0A01);
      repeat (6) step();
      chk_eq("mid_cnt_before", 32'(fifo_count), 32'h5);
      chk_eq("mid_x_out_before", 32'(x_out), 32'h0A01);
      do_reset(1);
      chk_reset_state("rst_mid");
      expect_s(1'b1, 16'h0000);
      expect_s(1'b1, 16'h0000);
      repeat (8) step();
      chk_eq("mid_max_cnt", 32'(max_cnt), 32'h0);
      end_of_test("mid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
